// File: rtl/logic_issue_pkg.sv
// Shared definitions for the logic issue stage: logic-unit select codes,
// decode field values and the issue-entry layout handed to the execute side.
package logic_issue_pkg;

    localparam int LOGIC_W = 3;

    localparam logic [LOGIC_W-1:0] LOGIC_AND  = 3'b000;
    localparam logic [LOGIC_W-1:0] LOGIC_OR   = 3'b001;
    localparam logic [LOGIC_W-1:0] LOGIC_XOR  = 3'b010;
    localparam logic [LOGIC_W-1:0] LOGIC_NAND = 3'b011;
    localparam logic [LOGIC_W-1:0] LOGIC_NOR  = 3'b100;

    localparam logic [1:0] DP_CLASS = 2'b00;
    localparam logic [1:0] LX_CLASS = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_ORR = 4'b1100;

    // Highest extension opcode that maps to a logic function (NOR).
    localparam logic [3:0] LX_OP_MAX = 4'b0100;

    typedef struct packed {
        logic [31:0]        a;
        logic [31:0]        b;
        logic [LOGIC_W-1:0] idx;
        logic [3:0]         rd;
        logic               s;
    } issue_entry_t;

    localparam int ENTRY_W = $bits(issue_entry_t);

endpackage

// File: rtl/logic_issue_fifo.sv
// Synchronous FIFO with power-of-two depth; full/empty come from an
// occupancy counter so they are available straight from registers.
module logic_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 72
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/logic_issue_stage.sv
// Issue stage: decodes logic-class instructions into a logic-unit select,
// queues them with their operands and counts illegal words.
module logic_issue_stage
    import logic_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_rn_val,
    input  logic [31:0]        in_op2_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_a,
    output logic [31:0]        out_b,
    output logic [LOGIC_W-1:0] out_logicidx,
    output logic [3:0]         out_rd,
    output logic               out_setflags,
    output logic               illegal_pulse,
    output logic [CNT_W-1:0]   illegal_count
);

    logic [3:0]         op;
    logic               legal;
    logic [LOGIC_W-1:0] idx;
    logic               accept;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [$clog2(DEPTH):0] fifo_count;
    issue_entry_t       wr_entry;
    issue_entry_t       head;
    issue_entry_t       last_q;
    issue_entry_t       shown;

    assign op = in_instr[24:21];

    always_comb begin
        legal = 1'b0;
        idx   = LOGIC_AND;
        case (in_instr[27:26])
            DP_CLASS: begin
                case (op)
                    OP_AND:  begin legal = 1'b1; idx = LOGIC_AND; end
                    OP_ORR:  begin legal = 1'b1; idx = LOGIC_OR;  end
                    OP_EOR:  begin legal = 1'b1; idx = LOGIC_XOR; end
                    default: begin legal = 1'b0; idx = LOGIC_AND; end
                endcase
            end
            LX_CLASS: begin
                if (op <= LX_OP_MAX) begin
                    legal = 1'b1;
                    idx   = op[LOGIC_W-1:0];
                end
            end
            default: begin
                legal = 1'b0;
                idx   = LOGIC_AND;
            end
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    assign wr_entry = '{a: in_rn_val, b: in_op2_val, idx: idx,
                        rd: in_instr[15:12], s: in_instr[20]};

    logic_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Ready depends only on registered occupancy, so a pop from full costs one bubble.
    assign in_ready  = !full;
    assign out_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (out_valid) begin
            last_q <= head;
        end
    end

    // While empty, the data outputs keep showing the last head presented.
    assign shown        = out_valid ? head : last_q;
    assign out_a        = shown.a;
    assign out_b        = shown.b;
    assign out_logicidx = shown.idx;
    assign out_rd       = shown.rd;
    assign out_setflags = shown.s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_pulse <= 1'b0;
            illegal_count <= '0;
        end else begin
            illegal_pulse <= accept && !legal;
            if (accept && !legal && (illegal_count != '1)) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_issue_stage.sv
// Self-checking bench for logic_issue_stage: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_logic_issue_stage;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_rn_val;
    logic [31:0]       in_op2_val;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_a;
    logic [31:0]       out_b;
    logic [2:0]        out_logicidx;
    logic [3:0]        out_rd;
    logic              out_setflags;
    logic              illegal_pulse;
    logic [CNT_W-1:0]  illegal_count;

    always #5 clk = ~clk;

    logic_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_rn_val     (in_rn_val),
        .in_op2_val    (in_op2_val),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_logicidx  (out_logicidx),
        .out_rd        (out_rd),
        .out_setflags  (out_setflags),
        .illegal_pulse (illegal_pulse),
        .illegal_count (illegal_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          idx;
        int          rd;
        int          s;
    } entry_t;

    entry_t q[$];
    entry_t last;
    int     ill_cnt;
    int     exp_pulse;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Spec decode rules: class 00 accepts AND/ORR/EOR, class 11 accepts ops 0..4.
    function automatic bit model_decode(input logic [31:0] w, output int idx);
        int cls;
        int op;
        cls = int'(w[27:26]);
        op  = int'(w[24:21]);
        idx = 0;
        if (cls == 0) begin
            if (op == 0)  begin idx = 0; return 1'b1; end
            if (op == 12) begin idx = 1; return 1'b1; end
            if (op == 1)  begin idx = 2; return 1'b1; end
            return 1'b0;
        end
        if (cls == 3 && op <= 4) begin
            idx = op;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        last      = '{a: 32'h0, b: 32'h0, idx: 0, rd: 0, s: 0};
        ill_cnt   = 0;
        exp_pulse = 0;
    endtask

    task automatic check_outputs();
        entry_t shown;
        shown = (q.size() > 0) ? q[0] : last;
        check_eq("in_ready",  64'(in_ready),      64'(q.size() < DEPTH));
        check_eq("out_valid", 64'(out_valid),     64'(q.size() > 0));
        check_eq("out_a",     64'(out_a),         64'(shown.a));
        check_eq("out_b",     64'(out_b),         64'(shown.b));
        check_eq("out_idx",   64'(out_logicidx),  64'(shown.idx));
        check_eq("out_rd",    64'(out_rd),        64'(shown.rd));
        check_eq("out_s",     64'(out_setflags),  64'(shown.s));
        check_eq("ill_pulse", 64'(illegal_pulse), 64'(exp_pulse));
        check_eq("ill_count", 64'(illegal_count), 64'(ill_cnt));
    endtask

    // Called at a falling edge: check, drive, advance the model across the next rising edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] rn,
                        input logic [31:0] op2, input bit ordy);
        bit     ready;
        bit     legal;
        int     idx;
        entry_t e;
        check_outputs();
        in_valid   = v;
        in_instr   = ins;
        in_rn_val  = rn;
        in_op2_val = op2;
        out_ready  = ordy;
        ready = (q.size() < DEPTH);
        legal = model_decode(ins, idx);
        if (q.size() > 0) last = q[0];
        exp_pulse = (v && ready && !legal) ? 1 : 0;
        if (v && ready && !legal && ill_cnt < CNT_MAX) ill_cnt++;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (v && ready && legal) begin
            e = '{a: rn, b: op2, idx: idx, rd: int'(ins[15:12]), s: int'(ins[20])};
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, 32'h0, 32'h0, ordy);
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid),     64'(0));
        check_eq("rst_pulse",     64'(illegal_pulse), 64'(0));
        check_eq("rst_count",     64'(illegal_count), 64'(0));
        check_eq("rst_out_a",     64'(out_a),         64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
            case ($urandom_range(0, 2))
                0:       w[27:21] = 7'b00_0000;
                1:       w[27:21] = 7'b00_1100;
                default: w[27:21] = 7'b00_0001;
            endcase
        end else if (sel == 1) begin
            w[27:26] = 2'b11;
            w[24:21] = 4'($urandom_range(0, 4));
        end
        return w;
    endfunction

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_rn_val  = '0;
        in_op2_val = '0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_out_valid", 64'(out_valid),     64'(0));
        check_eq("reset_out_a",     64'(out_a),         64'(0));
        check_eq("reset_count",     64'(illegal_count), 64'(0));
        rst_n = 1'b1;

        // Single AND, seen the cycle after acceptance
        step(1'b1, 32'hE001_2003, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // ORR then EOR into a stalled FIFO, then drain in order
        step(1'b1, 32'hE183_4000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        step(1'b1, 32'hE023_5000, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0);
        step(1'b1, 32'hE003_6000, 32'h1111_1111, 32'h2222_2222, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Extension space: NAND, NOR, then illegal op 5
        for (int op = 3; op <= 5; op++) begin
            step(1'b1, 32'hCC00_0000 | (32'(op) << 21) | 32'h0000_7000, $urandom, $urandom, 1'b1);
            idle(1'b1);
        end

        // Full FIFO: pop with in_valid held gives a bubble before the push lands
        step(1'b1, 32'hE001_1000, 32'h0000_0001, 32'h0000_0002, 1'b0);
        step(1'b1, 32'hE181_2000, 32'h0000_0003, 32'h0000_0004, 1'b0);
        step(1'b1, 32'hE021_3000, 32'h0000_0005, 32'h0000_0006, 1'b1);
        step(1'b1, 32'hE021_3000, 32'h0000_0005, 32'h0000_0006, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Drive the illegal counter into saturation
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            step(1'b1, 32'hE400_0000 | 32'($urandom_range(0, 32'h00FF_FFFF)), $urandom, $urandom, 1'b1);
        end
        idle(1'b1);

        // Reset with two entries queued
        step(1'b1, 32'hE001_2000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        step(1'b1, 32'hCC20_3000, 32'hCAFE_BABE, 32'h1357_9BDF, 1'b0);
        async_reset();
        idle(1'b1);

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
                     ($urandom_range(0, 9) < 6));
            end
        end
        idle(1'b1);
        idle(1'b1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
